// File: rtl/i2c_pkg.sv
// Shared types and default constants for the I2C register master.
// Holds the FSM state enum, the SCL phase enum and the default parameters.
package i2c_pkg;

  localparam int unsigned DefClkDiv  = 125;
  localparam logic [6:0]  DefDevAddr = 7'h20;

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StTxByte,
    StTxAck,
    StRestart,
    StRxByte,
    StMack,
    StStop,
    StDone
  } state_e;

  // Quarter periods of one SCL bit; SCL is released in the two middle phases.
  typedef enum logic [1:0] {
    PhSetup,
    PhHighA,
    PhHighB,
    PhLow
  } phase_e;

endpackage

// File: rtl/i2c_phase_gen.sv
// SCL quarter-period divider: emits a tick every CLK_DIV clocks and steps a 2-bit phase.
// Held cleared while run_i is low so every transaction starts at phase 0.
module i2c_phase_gen
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = DefClkDiv
) (
  input  logic   clk_i,
  input  logic   reset_i,
  input  logic   run_i,
  output logic   tick_o,
  output phase_e phase_o
);

  localparam int unsigned CntW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  phase_e          phase_q, phase_d;

  always_comb begin
    tick_o  = run_i && (cnt_q == CntMax);
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!run_i) begin
      cnt_d   = '0;
      phase_d = PhSetup;
    end else if (tick_o) begin
      cnt_d   = '0;
      phase_d = phase_e'(phase_q + 2'd1);
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      phase_q <= PhSetup;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/i2c_reg_master.sv
// I2C master performing single-register writes and reads (with repeated START) on one device.
// SCL and SDA are open-drain: the *_oe outputs pull the line low when set.
module i2c_reg_master
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DefClkDiv,
  parameter logic [6:0]  DEV_ADDR = DefDevAddr
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       read,
  input  logic [7:0] reg_dest,
  input  logic [7:0] data_to_send,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  output logic [7:0] data_read
);

  state_e     state_q, state_d;
  logic       start_q;
  logic       armed_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  logic       rd_q, rd_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] data_q, data_d;
  logic       nack_q, nack_d;
  logic       ack_error_q, ack_error_d;
  logic [7:0] data_read_q, data_read_d;
  logic       scl_oe_q, scl_oe_d;
  logic       sda_oe_q, sda_oe_d;

  logic   tick;
  phase_e phase;
  logic   launch;
  logic   scl_low;
  logic   end_bit;
  logic   sample;

  assign busy = (state_q != StIdle);

  i2c_phase_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_gen (
    .clk_i   (clk),
    .reset_i (reset),
    .run_i   (busy),
    .tick_o  (tick),
    .phase_o (phase)
  );

  // armed_q blocks a start level that was already high when reset released.
  assign launch  = start && !start_q && !busy && armed_q;
  assign scl_low = (phase == PhSetup) || (phase == PhLow);
  assign end_bit = tick && (phase == PhLow);
  assign sample  = tick && (phase == PhHighA);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_idx_d  = byte_idx_q;
    rd_d        = rd_q;
    reg_d       = reg_q;
    data_d      = data_q;
    nack_d      = nack_q;
    ack_error_d = ack_error_q;
    data_read_d = data_read_q;
    scl_oe_d    = 1'b0;
    sda_oe_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (launch) begin
          state_d     = StStart;
          rd_d        = read;
          reg_d       = reg_dest;
          data_d      = data_to_send;
          ack_error_d = 1'b0;
          byte_idx_d  = 2'd0;
        end
      end

      StStart: begin
        // SDA falls at the start of the second high phase while SCL is released.
        sda_oe_d = (phase == PhHighB) || (phase == PhLow);
        scl_oe_d = (phase == PhLow);
        if (end_bit) begin
          state_d    = StTxByte;
          shift_d    = {DEV_ADDR, 1'b0};
          bit_cnt_d  = 3'd0;
          byte_idx_d = 2'd0;
        end
      end

      StTxByte: begin
        scl_oe_d = scl_low;
        sda_oe_d = !shift_q[7];
        if (end_bit) begin
          if (bit_cnt_q == 3'd7) begin
            state_d = StTxAck;
          end else begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

      StTxAck: begin
        scl_oe_d = scl_low;
        if (sample) begin
          nack_d = sda_in;
        end
        if (end_bit) begin
          bit_cnt_d = 3'd0;
          if (nack_q) begin
            ack_error_d = 1'b1;
            state_d     = StStop;
          end else begin
            unique case (byte_idx_q)
              2'd0: begin
                state_d    = StTxByte;
                shift_d    = reg_q;
                byte_idx_d = 2'd1;
              end
              2'd1: begin
                if (rd_q) begin
                  state_d = StRestart;
                end else begin
                  state_d    = StTxByte;
                  shift_d    = data_q;
                  byte_idx_d = 2'd2;
                end
              end
              2'd2: state_d = rd_q ? StRxByte : StStop;
              default: state_d = StStop;
            endcase
          end
        end
      end

      StRestart: begin
        scl_oe_d = scl_low;
        sda_oe_d = (phase == PhHighB) || (phase == PhLow);
        if (end_bit) begin
          state_d    = StTxByte;
          shift_d    = {DEV_ADDR, 1'b1};
          bit_cnt_d  = 3'd0;
          byte_idx_d = 2'd2;
        end
      end

      StRxByte: begin
        scl_oe_d = scl_low;
        if (sample) begin
          shift_d = {shift_q[6:0], sda_in};
        end
        if (end_bit) begin
          if (bit_cnt_q == 3'd7) begin
            state_d     = StMack;
            data_read_d = shift_q;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

      StMack: begin
        // SDA stays released: a NACK ends the single-byte read.
        scl_oe_d = scl_low;
        if (end_bit) begin
          state_d = StStop;
        end
      end

      StStop: begin
        // SDA rises at the start of the second high phase while SCL is released.
        scl_oe_d = (phase == PhSetup);
        sda_oe_d = (phase == PhSetup) || (phase == PhHighA);
        if (end_bit) begin
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      armed_q     <= !start;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      byte_idx_q  <= 2'd0;
      rd_q        <= 1'b0;
      reg_q       <= 8'h00;
      data_q      <= 8'h00;
      nack_q      <= 1'b0;
      ack_error_q <= 1'b0;
      data_read_q <= 8'h00;
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      armed_q     <= armed_q || !start;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_idx_q  <= byte_idx_d;
      rd_q        <= rd_d;
      reg_q       <= reg_d;
      data_q      <= data_d;
      nack_q      <= nack_d;
      ack_error_q <= ack_error_d;
      data_read_q <= data_read_d;
      scl_oe_q    <= scl_oe_d;
      sda_oe_q    <= sda_oe_d;
    end
  end

  assign done      = (state_q == StDone);
  assign ack_error = ack_error_q;
  assign data_read = data_read_q;
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;

endmodule

// File: tb/tb_i2c_reg_master.sv
// Directed bench for i2c_reg_master with an open-drain bus and a simple register slave.
// The slave logs START/STOP and every byte with its ninth (ACK) bit for comparison.
module tb_i2c_reg_master;

  localparam int LogS = 512;
  localparam int LogP = 513;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       read = 1'b0;
  logic [7:0] reg_dest = 8'h00;
  logic [7:0] data_to_send = 8'h00;
  logic       scl_oe, sda_oe, busy, done, ack_error;
  logic [7:0] data_read;
  wire        sda_in;

  int n_tests = 0;
  int n_fail  = 0;

  // Slave model state.
  logic       drive = 1'b0;
  logic       ack_en = 1'b1;
  logic       scl_p = 1'b1;
  logic       sda_p = 1'b1;
  logic       tx_on = 1'b0;
  logic [7:0] cur = 8'h00;
  logic [7:0] tx = 8'hA5;
  int         bitn = 0;
  int         byte_no = 0;
  int         log_q[$];
  int         exp_q[$];

  wire scl = !scl_oe;
  wire sda = !(sda_oe || drive);
  assign sda_in = sda;

  always #5 clk = ~clk;

  i2c_reg_master #(
    .CLK_DIV  (4),
    .DEV_ADDR (7'h20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .read         (read),
    .reg_dest     (reg_dest),
    .data_to_send (data_to_send),
    .scl_oe       (scl_oe),
    .sda_oe       (sda_oe),
    .sda_in       (sda_in),
    .busy         (busy),
    .done         (done),
    .ack_error    (ack_error),
    .data_read    (data_read)
  );

  always @(posedge clk) begin
    scl_p <= scl;
    sda_p <= sda;
    if (scl && scl_p && sda_p && !sda) begin
      log_q.push_back(LogS);
      bitn    <= 0;
      byte_no <= 0;
      tx_on   <= 1'b0;
      drive   <= 1'b0;
    end else if (scl && scl_p && !sda_p && sda) begin
      log_q.push_back(LogP);
      bitn    <= 0;
      byte_no <= 0;
      tx_on   <= 1'b0;
      drive   <= 1'b0;
    end else if (scl && !scl_p) begin
      if (bitn < 8) begin
        cur  <= {cur[6:0], sda};
        bitn <= bitn + 1;
      end else begin
        log_q.push_back({23'd0, sda, cur});
        bitn    <= 0;
        byte_no <= byte_no + 1;
        if (byte_no == 0 && cur[0] && !sda) tx_on <= 1'b1;
        else if (tx_on && sda) tx_on <= 1'b0;
      end
    end else if (!scl && scl_p) begin
      if (bitn == 8) drive <= !tx_on && ack_en;
      else if (tx_on) drive <= !tx[3'(7 - bitn)];
      else drive <= 1'b0;
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic rd, input logic [7:0] rg, input logic [7:0] dt);
    read         = rd;
    reg_dest     = rg;
    data_to_send = dt;
    start        = 1'b1;
    check_eq("busy_before_launch", busy, 0);
    step();
    check_eq("busy_after_launch", busy, 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 4000) begin
      step();
      n++;
    end
    check_eq({tag, "_done_seen"}, done, 1);
    if (done) begin
      step();
      check_eq({tag, "_done_pulse"}, done, 0);
      check_eq({tag, "_busy_drop"}, busy, 0);
    end
  endtask

  task automatic compare_log(input string tag);
    check_eq({tag, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check_eq($sformatf("%s_%0d", tag, i), (i < log_q.size()) ? log_q[i] : -1, exp_q[i]);
    end
  endtask

  initial begin
    int n;
    repeat (3) step();
    reset = 1'b0;
    step();
    check_eq("rst_scl_oe", scl_oe, 0);
    check_eq("rst_sda_oe", sda_oe, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ack_error", ack_error, 0);
    check_eq("rst_data_read", data_read, 8'h00);

    // Register write.
    log_q.delete();
    launch(1'b0, 8'h0F, 8'h80);
    start = 1'b0;
    wait_done("wr");
    exp_q = '{LogS, 'h040, 'h00F, 'h080, LogP};
    compare_log("wr_log");
    check_eq("wr_ack_error", ack_error, 0);

    // Register read, slave returns 0xA5, master NACKs the data byte.
    log_q.delete();
    launch(1'b1, 8'h10, 8'h00);
    start = 1'b0;
    wait_done("rd");
    exp_q = '{LogS, 'h040, 'h010, LogS, 'h041, 'h1A5, LogP};
    compare_log("rd_log");
    check_eq("rd_data", data_read, 8'hA5);
    check_eq("rd_ack_error", ack_error, 0);

    // Silent slave: address NACK, STOP straight after the ninth clock.
    ack_en = 1'b0;
    log_q.delete();
    launch(1'b1, 8'h22, 8'h00);
    start = 1'b0;
    wait_done("nack");
    exp_q = '{LogS, 'h140, LogP};
    compare_log("nack_log");
    check_eq("nack_ack_error", ack_error, 1);
    check_eq("nack_data_hold", data_read, 8'hA5);
    ack_en = 1'b1;

    // Second start edge and changed inputs during a write have no effect.
    log_q.delete();
    launch(1'b0, 8'h0F, 8'h80);
    check_eq("launch_clears_ack_error", ack_error, 0);
    repeat (40) step();
    start        = 1'b0;
    read         = 1'b1;
    reg_dest     = 8'h55;
    data_to_send = 8'h33;
    repeat (3) step();
    start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    wait_done("ign");
    exp_q = '{LogS, 'h040, 'h00F, 'h080, LogP};
    compare_log("ign_log");
    check_eq("ign_data_hold", data_read, 8'hA5);

    // Reset during the fourth bit of the register byte; start stays high through it.
    log_q.delete();
    launch(1'b0, 8'h0F, 8'h80);
    n = 0;
    while (!(log_q.size() == 2 && bitn == 4) && n < 3000) begin
      step();
      n++;
    end
    check_eq("mid_reached_bit4", (log_q.size() == 2 && bitn == 4) ? 1 : 0, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("mid_scl_oe", scl_oe, 0);
    check_eq("mid_sda_oe", sda_oe, 0);
    check_eq("mid_busy", busy, 0);
    check_eq("mid_data_read", data_read, 8'h00);
    repeat (10) step();
    check_eq("held_start_no_launch", busy, 0);
    start = 1'b0;
    step();
    log_q.delete();
    launch(1'b0, 8'h3C, 8'h5A);
    start = 1'b0;
    wait_done("post");
    exp_q = '{LogS, 'h040, 'h03C, 'h05A, LogP};
    compare_log("post_log");
    check_eq("post_ack_error", ack_error, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
